rv_decode_stage: RTL

- Decode stage directly upstream of the integer ALU.
- Accepts 32-bit RV64 instruction words from fetch over a valid/ready handshake and checks them against the ALU-supported opcode set.
- Splits each legal word into the ALU operand fields (regA, regB, opcode, regDest) and buffers up to two decoded entries.
- Drops illegal words and reports them with their PC.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/rv_decode_fifo.sv | 55 +++++
 rtl/rv_decode_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: base opcodes, funct7 groups, 10-bit ALU opcodes
// and the decoded-entry record handed from decode to the ALU.
package alu_pkg;

    localparam int DEFAULT_XLEN = 64;

    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_IMM32 = 7'h1b;
    localparam logic [6:0] OP       = 7'h33;
    localparam logic [6:0] OP32     = 7'h3b;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_MULDIV = 7'h01;
    localparam logic [6:0] F7_ALT    = 7'h20;

    // ALU opcode is {funct3, base opcode}
    localparam logic [9:0] opcode_addi       = 10'h013;
    localparam logic [9:0] opcode_slli       = 10'h093;
    localparam logic [9:0] opcode_slti       = 10'h113;
    localparam logic [9:0] opcode_sltiu      = 10'h193;
    localparam logic [9:0] opcode_xori       = 10'h213;
    localparam logic [9:0] opcode_srxi       = 10'h293;
    localparam logic [9:0] opcode_ori        = 10'h313;
    localparam logic [9:0] opcode_andi       = 10'h393;
    localparam logic [9:0] opcode_addiw      = 10'h01b;
    localparam logic [9:0] opcode_addsubmul  = 10'h033;
    localparam logic [9:0] opcode_addsubmulw = 10'h03b;

    typedef struct packed {
        logic [4:0]              regA;
        logic [11:0]             regB;
        logic [9:0]              opcode;
        logic [4:0]              regDest;
        logic                    we;
        logic [DEFAULT_XLEN-1:0] pc;
    } decoded_t;

    function automatic logic [9:0] alu_opcode(input logic [31:0] insn);
        return {insn[14:12], insn[6:0]};
    endfunction

endpackage

// File: rtl/rv_decode_fifo.sv
// Two-entry FIFO of decoded entries; the head entry drives the ALU directly.
module rv_decode_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     push,
    input  logic     pop,
    input  decoded_t din,
    output logic     full,
    output logic     empty,
    output decoded_t head
);

    decoded_t   mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'(DEPTH));
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a write when the head leaves the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Decode stage ahead of the integer ALU: screens fetch words against the ALU
// opcode set, splits legal ones into operand fields and reports illegal ones.
module rv_decode_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_regA,
    output logic [11:0]     out_regB,
    output logic [9:0]      out_opcode,
    output logic [4:0]      out_regDest,
    output logic            out_we,
    output logic [XLEN-1:0] out_pc,
    output logic            illegal,
    output logic [XLEN-1:0] illegal_pc
);

    logic       accept;
    logic       legal;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic       report;
    decoded_t   din;
    decoded_t   head;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign funct3 = in_insn[14:12];
    assign funct7 = in_insn[31:25];

    // in_ready decodes only the registered count, so out_ready never reaches it
    assign in_ready  = !full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal && !flush;
    assign report    = accept && !legal && !flush;
    assign pop       = out_valid && out_ready;
    assign out_valid = !empty;

    always_comb begin
        legal = 1'b0;
        if (in_insn[1:0] == 2'b11) begin
            case (in_insn[6:0])
                OP_IMM: begin
                    case (funct3)
                        3'd1:    legal = (in_insn[31:26] == 6'b000000);
                        3'd5:    legal = (in_insn[31:26] == 6'b000000) || (in_insn[31:26] == 6'b010000);
                        default: legal = 1'b1;
                    endcase
                end
                OP_IMM32: begin
                    case (funct3)
                        3'd0:    legal = 1'b1;
                        3'd1:    legal = (funct7 == 7'b0000000);
                        3'd5:    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        default: legal = 1'b0;
                    endcase
                end
                OP: begin
                    case (funct7)
                        F7_BASE, F7_MULDIV: legal = 1'b1;
                        F7_ALT:             legal = (funct3 == 3'd0) || (funct3 == 3'd5);
                        default:            legal = 1'b0;
                    endcase
                end
                OP32: begin
                    case (funct7)
                        F7_BASE:   legal = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd5);
                        F7_MULDIV: legal = (funct3 == 3'd0) || (funct3 >= 3'd4);
                        F7_ALT:    legal = (funct3 == 3'd0) || (funct3 == 3'd5);
                        default:   legal = 1'b0;
                    endcase
                end
                default: legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        din         = '0;
        din.regA    = in_insn[19:15];
        din.regB    = in_insn[31:20];
        din.opcode  = alu_opcode(in_insn);
        din.regDest = in_insn[11:7];
        din.we      = (in_insn[11:7] != 5'd0);
        din.pc      = in_pc;
    end

    rv_decode_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .push (push),
        .pop  (pop),
        .din  (din),
        .full (full),
        .empty(empty),
        .head (head)
    );

    assign out_regA    = head.regA;
    assign out_regB    = head.regB;
    assign out_opcode  = head.opcode;
    assign out_regDest = head.regDest;
    assign out_we      = head.we;
    assign out_pc      = head.pc;

    // Illegal report is dropped along with the word when a flush coincides
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal    <= 1'b0;
            illegal_pc <= '0;
        end else begin
            illegal <= report;
            if (report) begin
                illegal_pc <= in_pc;
            end
        end
    end

endmodule
